// File: rtl/thread_fetch_issue_if.sv
// Fetch/issue bus for the 4-thread fetch unit: control in,
// BRAM port, and issue register out.
interface thread_fetch_issue_if #(
  parameter int PC_W = 9
);
  logic [3:0]      thread_en;
  logic            stall;
  logic            br_valid;
  logic [1:0]      br_tid;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            issue_valid;
  logic [1:0]      issue_tid;
  logic [PC_W-1:0] issue_pc;
  logic [31:0]     issue_instr;
  logic [3:0]      issue_op;

  modport master (
    input  thread_en, stall,
    input  br_valid, br_tid, br_target,
    input  imem_rdata,
    output imem_addr,
    output issue_valid, issue_tid,
    output issue_pc, issue_instr,
    output issue_op
  );

  modport slave (
    output thread_en, stall,
    output br_valid, br_tid, br_target,
    output imem_rdata,
    input  imem_addr,
    input  issue_valid, issue_tid,
    input  issue_pc, issue_instr,
    input  issue_op
  );
endinterface

// File: rtl/thread_fetch_issue.sv
// Round-robin 4-thread instruction fetch with a 1-cycle BRAM,
// an F stage tracking the read and an I stage holding the issue.
module thread_fetch_issue #(
  parameter int PC_W = 9
) (
  input logic                 clk,
  input logic                 reset_n,
  thread_fetch_issue_if.master bus
);

  logic [PC_W-1:0] pc_q [4];
  logic [1:0]      rr_q;
  logic            f_valid_q;
  logic [1:0]      f_tid_q;
  logic [PC_W-1:0] f_pc_q;
  logic            i_valid_q;
  logic [1:0]      i_tid_q;
  logic [PC_W-1:0] i_pc_q;
  logic [31:0]     i_instr_q;

  logic [1:0]      sel;
  logic [1:0]      idx;
  logic            found;
  logic            br_hit;
  logic [PC_W-1:0] fetch_pc;
  logic            br_f;
  logic            br_i;

  // Search starts just after the last winner so rr itself is last.
  always_comb begin
    sel   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_q + k[1:0];
      if (!found && bus.thread_en[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign br_hit = found && bus.br_valid
                  && (bus.br_tid == sel);
  assign fetch_pc = br_hit ? bus.br_target
                           : pc_q[sel];
  assign br_f = bus.br_valid && (f_tid_q == bus.br_tid);
  assign br_i = bus.br_valid && (i_tid_q == bus.br_tid);

  assign bus.imem_addr   = bus.stall ? f_pc_q : fetch_pc;
  assign bus.issue_valid = i_valid_q;
  assign bus.issue_tid   = i_tid_q;
  assign bus.issue_pc    = i_pc_q;
  assign bus.issue_instr = i_instr_q;
  assign bus.issue_op    = i_instr_q[31:28];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < 4; t++)
        pc_q[t] <= {t[1:0], {(PC_W-2){1'b0}}};
      rr_q      <= 2'd3;
      f_valid_q <= 1'b0;
      f_tid_q   <= '0;
      f_pc_q    <= '0;
      i_valid_q <= 1'b0;
      i_tid_q   <= '0;
      i_pc_q    <= '0;
      i_instr_q <= '0;
    end else begin
      if (!bus.stall) begin
        f_valid_q <= found;
        f_tid_q   <= sel;
        f_pc_q    <= fetch_pc;
        if (found) begin
          pc_q[sel] <= fetch_pc + 1'b1;
          rr_q      <= sel;
        end
        i_valid_q <= f_valid_q && !br_f;
        i_tid_q   <= f_tid_q;
        i_pc_q    <= f_pc_q;
        i_instr_q <= bus.imem_rdata;
      end else begin
        if (br_f) f_valid_q <= 1'b0;
        if (br_i) i_valid_q <= 1'b0;
      end
      // A redirect that is also this cycle's fetch has consumed target.
      if (bus.br_valid)
        pc_q[bus.br_tid] <= (br_hit && !bus.stall)
                            ? bus.br_target + 1'b1
                            : bus.br_target;
    end
  end

endmodule

// File: tb/tb_thread_fetch_issue.sv
// Directed bench for thread_fetch_issue: round robin, enables,
// stall, branch redirect, PC wrap and mid-stream reset.
module tb_thread_fetch_issue;

  logic clk = 1'b0;
  logic reset_n;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;
  logic [31:0] w;
  logic [8:0]  expa [8] = '{9'd0, 9'd128, 9'd256, 9'd384,
                            9'd1, 9'd129, 9'd257, 9'd385};
  logic [8:0]  expb [6] = '{9'd0, 9'd256, 9'd1,
                            9'd257, 9'd2, 9'd258};

  thread_fetch_issue_if #(.PC_W(9)) bus ();

  thread_fetch_issue #(.PC_W(9)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {a[3:0], 19'h2A5A5, a};
  endfunction

  always @(posedge clk) bus.imem_rdata <= word(bus.imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] en);
    bus.thread_en = en;
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_tid    = 2'd0;
    bus.br_target = 9'd0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic chk_iss(input string tag, input logic [1:0] tid,
                         input logic [8:0] pc);
    w = word(pc);
    chk({tag, "_v"}, 32'(bus.issue_valid), 32'd1);
    chk({tag, "_tid"}, 32'(bus.issue_tid), 32'(tid));
    chk({tag, "_pc"}, 32'(bus.issue_pc), 32'(pc));
    chk({tag, "_ins"}, bus.issue_instr, w);
    chk({tag, "_op"}, 32'(bus.issue_op), 32'(w[31:28]));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bus.thread_en = 4'hF;
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_tid    = 2'd0;
    bus.br_target = 9'd0;
    #2;
    chk("rst_v", 32'(bus.issue_valid), 32'd0);
    chk("rst_tid", 32'(bus.issue_tid), 32'd0);
    chk("rst_pc", 32'(bus.issue_pc), 32'd0);
    chk("rst_ins", bus.issue_instr, 32'd0);
    chk("rst_op", 32'(bus.issue_op), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    tick(1);

    // all four threads round robin
    do_reset(4'hF);
    for (int c = 0; c < 8; c++) begin
      chk("rr_addr", 32'(bus.imem_addr), 32'(expa[c]));
      if (c >= 2) chk_iss("rr", 2'((c - 2) % 4), expa[c-2]);
      else chk("rr_v0", 32'(bus.issue_valid), 32'd0);
      tick(1);
    end

    // threads 0 and 2 only, then all disabled
    do_reset(4'b0101);
    for (int c = 0; c < 6; c++) begin
      chk("en_addr", 32'(bus.imem_addr), 32'(expb[c]));
      if (c >= 2) chk_iss("en", 2'(((c - 2) % 2) * 2), expb[c-2]);
      tick(1);
    end
    bus.thread_en = 4'b0000;
    #1;
    chk_iss("off6", 2'd0, 9'd2);
    tick(1);
    chk_iss("off7", 2'd2, 9'd258);
    tick(1);
    chk("off8_v", 32'(bus.issue_valid), 32'd0);
    tick(1);
    chk("off9_v", 32'(bus.issue_valid), 32'd0);

    // stall for three edges with thread 1 in I
    do_reset(4'hF);
    tick(3);
    bus.stall = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk_iss("stl", 2'd1, 9'd128);
      chk("stl_addr", 32'(bus.imem_addr), 32'd256);
      tick(1);
    end
    bus.stall = 1'b0;
    #1;
    chk_iss("rel6", 2'd1, 9'd128);
    chk("rel6_addr", 32'(bus.imem_addr), 32'd384);
    tick(1);
    chk_iss("rel7", 2'd2, 9'd256);
    chk("rel7_addr", 32'(bus.imem_addr), 32'd1);
    tick(1);
    chk_iss("rel8", 2'd3, 9'd384);
    chk("rel8_addr", 32'(bus.imem_addr), 32'd129);
    tick(1);
    chk_iss("rel9", 2'd0, 9'd1);

    // redirect thread 2 while its fetch sits in F
    do_reset(4'hF);
    tick(3);
    bus.br_valid  = 1'b1;
    bus.br_tid    = 2'd2;
    bus.br_target = 9'd300;
    #1;
    chk("br_addr3", 32'(bus.imem_addr), 32'd384);
    tick(1);
    bus.br_valid = 1'b0;
    #1;
    chk("br_sq_v", 32'(bus.issue_valid), 32'd0);
    chk("br_addr4", 32'(bus.imem_addr), 32'd1);
    tick(1);
    chk_iss("br5", 2'd3, 9'd384);
    tick(1);
    chk("br_addr6", 32'(bus.imem_addr), 32'd300);
    tick(2);
    chk_iss("br8", 2'd2, 9'd300);
    tick(2);
    chk("br_addr10", 32'(bus.imem_addr), 32'd301);
    tick(2);
    chk_iss("br12", 2'd2, 9'd301);

    // redirect of the thread being selected this cycle
    do_reset(4'hF);
    tick(1);
    bus.br_valid  = 1'b1;
    bus.br_tid    = 2'd1;
    bus.br_target = 9'd50;
    #1;
    chk("bs_addr1", 32'(bus.imem_addr), 32'd50);
    tick(1);
    bus.br_valid = 1'b0;
    #1;
    chk_iss("bs2", 2'd0, 9'd0);
    tick(1);
    chk_iss("bs3", 2'd1, 9'd50);
    tick(2);
    chk("bs_addr5", 32'(bus.imem_addr), 32'd51);

    // thread 3 wraps from 511 to 0, then async reset mid-stream
    do_reset(4'hF);
    bus.br_valid  = 1'b1;
    bus.br_tid    = 2'd3;
    bus.br_target = 9'd511;
    #1;
    chk("wr_addr0", 32'(bus.imem_addr), 32'd0);
    tick(1);
    bus.br_valid = 1'b0;
    tick(2);
    chk("wr_addr3", 32'(bus.imem_addr), 32'd511);
    tick(2);
    chk_iss("wr5", 2'd3, 9'd511);
    tick(2);
    chk("wr_addr7", 32'(bus.imem_addr), 32'd0);
    tick(1);
    chk("pre_rst_v", 32'(bus.issue_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(bus.issue_valid), 32'd0);
    chk("mid_rst_pc", 32'(bus.issue_pc), 32'd0);
    chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rs_addr0", 32'(bus.imem_addr), 32'd0);
    tick(1);
    chk("rs_addr1", 32'(bus.imem_addr), 32'd128);
    chk("rs_v1", 32'(bus.issue_valid), 32'd0);
    tick(1);
    chk_iss("rs2", 2'd0, 9'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/thread_fetch_issue.md
THREAD_FETCH_ISSUE -- requirements
Module: thread_fetch_issue

Interface
REQ-001 Parameter PC_W, default 9, meaning instruction-memory word-address width; the thread count is fixed at 4.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 thread_en  input  4  per-thread fetch enable; bit t enables thread t.
REQ-005 stall  input  1  downstream hold; 1 means the issue outputs are not consumed this cycle.
REQ-006 br_valid  input  1  branch redirect strobe from the execute stage.
REQ-007 br_tid  input  2  thread being redirected.
REQ-008 br_target  input  PC_W  new word PC for br_tid.
REQ-009 imem_addr  output  PC_W  word address to the synchronous instruction BRAM, which has 1-cycle read latency.
REQ-010 imem_rdata  input  32  instruction word, equal to mem[address presented before the previous edge].
REQ-011 issue_valid  output  1  the issue register holds a live instruction.
REQ-012 issue_tid  output  2  thread of the issued instruction.
REQ-013 issue_pc  output  PC_W  PC of the issued instruction.
REQ-014 issue_instr  output  32  the issued instruction word.
REQ-015 issue_op  output  4  issue_instr[31:28], the opcode field consumed by the control unit.

Function
REQ-016 The block SHALL hold per-thread PC registers pc[0..3] and a 2-bit last-selected pointer rr.
REQ-017 The pipeline SHALL have two register stages: F (f_valid, f_tid, f_pc) tracks the outstanding BRAM read; I drives the issue_* outputs.
REQ-018 Selection: sel SHALL be the first enabled thread in the order rr+1, rr+2, rr+3, rr (mod 4); if thread_en==0, no fetch is launched.
REQ-019 The fetch PC SHALL be br_target when br_valid and br_tid==sel, else pc[sel].
REQ-020 When stall=0: imem_addr = fetch PC (combinational); at the edge, F <= {selection found, sel, fetch PC}; pc[sel] <= fetch PC+1 (mod 2^PC_W); rr <= sel; I <= {f_valid, f_tid, f_pc, imem_rdata}.
REQ-021 When stall=1: imem_addr = f_pc; F, I, rr and all pc[] SHALL hold, except for branch effects (REQ-022..024).
REQ-022 On br_valid, pc[br_tid] SHALL load br_target (or br_target+1 when REQ-019 applies), regardless of stall.
REQ-023 On br_valid, f_valid SHALL clear at the edge if f_tid==br_tid; the new fetch under REQ-019 is not squashed.
REQ-024 On br_valid, the I stage SHALL be squashed (issue_valid=0 next cycle) if it would hold br_tid: under stall=0 if f_tid==br_tid, under stall=1 if issue_tid==br_tid.
REQ-025 Fetch-to-issue latency SHALL be 2 edges: a PC selected at edge k appears on issue_* after edge k+1.
REQ-026 Clearing a thread_en bit SHALL stop new fetches for that thread but SHALL NOT squash its in-flight F/I entries.
REQ-027 issue_op SHALL always equal issue_instr[31:28], including when issue_valid=0.

Reset
REQ-028 With reset_n=0, immediately and asynchronously: pc[t] = t<<(PC_W-2) (0,128,256,384 for PC_W=9); rr=3; f_valid=0; issue_valid=0; issue_tid=0; issue_pc=0; issue_instr=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight fetches; the first fetch after release SHALL be thread 0 (if enabled) at its reset PC.

Verification
REQ-030 Reset release with thread_en=4'hF, stall=0 -> imem_addr 0,128,256,384,1,... on consecutive cycles; issue_tid 0,1,2,3,0 from the 2nd cycle after the first fetch; issue_op = mem[pc][31:28].
REQ-031 thread_en=4'b0101 -> threads 0 and 2 alternate; pcs 0,256,1,257; thread_en=0 -> issue_valid falls after 2 cycles.
REQ-032 stall held 3 cycles with I={tid1,pc128} -> issue outputs and imem_addr are frozen; after release the sequence resumes with no duplicated or skipped PC.
REQ-033 br_valid, br_tid=2, br_target=300 while F holds thread 2 -> that fetch is squashed; the next thread-2 issue has issue_pc=300, then 301.
REQ-034 br_valid, br_tid==sel, same cycle -> imem_addr=br_target in that cycle; pc[sel]=br_target+1.
REQ-035 Thread 3 at pc=511 (PC_W=9) -> next thread-3 PC wraps to 0; reset_n pulsed low mid-stream -> issue_valid=0 immediately and the sequence restarts per REQ-029.
